// File: rtl/alu_arb_if.sv
// Bundle of request, ALU and response signals for alu_arb.
// slave = arbiter side, master = issue/ALU/consumer side.
interface alu_arb_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             r0_valid;
    logic             r0_ready;
    logic [14:0]      r0_op;
    logic [XLEN-1:0]  r0_a;
    logic [XLEN-1:0]  r0_b;
    logic [TAG_W-1:0] r0_tag;
    logic             r1_valid;
    logic             r1_ready;
    logic [14:0]      r1_op;
    logic [XLEN-1:0]  r1_a;
    logic [XLEN-1:0]  r1_b;
    logic [TAG_W-1:0] r1_tag;
    logic [6:0]       alu_funct7;
    logic [2:0]       alu_funct3;
    logic [4:0]       alu_opcode;
    logic [XLEN-1:0]  alu_in1;
    logic [XLEN-1:0]  alu_in2;
    logic [XLEN-1:0]  alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [XLEN-1:0]  rsp_data;
    logic             rsp_illegal;
    logic             busy;

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b, r0_tag,
        input  r1_valid, r1_op, r1_a, r1_b, r1_tag,
        input  alu_out, rsp_ready,
        output r0_ready, r1_ready,
        output alu_funct7, alu_funct3, alu_opcode,
        output alu_in1, alu_in2,
        output rsp_valid, rsp_id, rsp_tag,
        output rsp_data, rsp_illegal, busy
    );

    modport master (
        output r0_valid, r0_op, r0_a, r0_b, r0_tag,
        output r1_valid, r1_op, r1_a, r1_b, r1_tag,
        output alu_out, rsp_ready,
        input  r0_ready, r1_ready,
        input  alu_funct7, alu_funct3, alu_opcode,
        input  alu_in1, alu_in2,
        input  rsp_valid, rsp_id, rsp_tag,
        input  rsp_data, rsp_illegal, busy
    );
endinterface

// File: rtl/alu_arb.sv
// Round-robin two-requester sequencer for the shared registered ALU.
// Optional ALU_ARB_LEGAL_CHECK_EN: reject non R-type encodings in IDLE.
module alu_arb #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    alu_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t           state;
    state_t           state_d;
    logic             last;
    logic             g0;
    logic             g1;
    logic             acc;
    logic             bad;
    logic [14:0]      gop;
    logic [XLEN-1:0]  ga;
    logic [XLEN-1:0]  gb;
    logic [TAG_W-1:0] gtag;
    logic [6:0]       f7_q;
    logic [2:0]       f3_q;
    logic [4:0]       opc_q;
    logic [XLEN-1:0]  in1_q;
    logic [XLEN-1:0]  in2_q;
    logic             vld_q;
    logic             id_q;
    logic             ill_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  data_q;

    // Grant: r0 unless both valid and r0 was granted last
    always_comb begin
        g0   = bus.r0_valid && (!bus.r1_valid || last);
        g1   = bus.r1_valid && !g0;
        acc  = rst && (state == IDLE) && (g0 || g1);
        gop  = g1 ? bus.r1_op  : bus.r0_op;
        ga   = g1 ? bus.r1_a   : bus.r0_a;
        gb   = g1 ? bus.r1_b   : bus.r0_b;
        gtag = g1 ? bus.r1_tag : bus.r0_tag;
    end

    assign bus.r0_ready = acc && g0;
    assign bus.r1_ready = acc && g1;

`ifdef ALU_ARB_LEGAL_CHECK_EN
    // Only the ten R-type integer ops are legal
    always_comb begin
        bad = 1'b1;
        if (gop[4:0] == 5'b01100) begin
            unique case (1'b1)
                gop[14:8] == 7'h00: bad = 1'b0;
                gop[14:8] == 7'h20:
                    bad = !(gop[7:5] == 3'b000 ||
                            gop[7:5] == 3'b101);
                default: bad = 1'b1;
            endcase
        end
    end
`else
    assign bad = 1'b0;
`endif

    // Next state; illegal ops skip the ALU entirely
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (acc) state_d = bad ? RESP : EXEC;
            EXEC: state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: if (vld_q && bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Operand hold, grant history and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last   <= 1'b1;
            f7_q   <= '0;
            f3_q   <= '0;
            opc_q  <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            vld_q  <= 1'b0;
            id_q   <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            if (acc) begin
                last  <= g1;
                id_q  <= g1;
                tag_q <= gtag;
                ill_q <= bad;
                if (bad) begin
                    data_q <= '0;
                end else begin
                    f7_q  <= gop[14:8];
                    f3_q  <= gop[7:5];
                    opc_q <= gop[4:0];
                    in1_q <= ga;
                    in2_q <= gb;
                end
            end
            if (state == CAPT) begin
                data_q <= bus.alu_out;
                vld_q  <= 1'b1;
            end
            if (state == RESP) begin
                if (!vld_q)             vld_q <= 1'b1;
                else if (bus.rsp_ready) vld_q <= 1'b0;
            end
        end
    end

    assign bus.alu_funct7  = f7_q;
    assign bus.alu_funct3  = f3_q;
    assign bus.alu_opcode  = opc_q;
    assign bus.alu_in1     = in1_q;
    assign bus.alu_in2     = in2_q;
    assign bus.rsp_valid   = vld_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_tag     = tag_q;
    assign bus.rsp_data    = data_q;
    assign bus.rsp_illegal = ill_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: vector table, corner sequences and random rounds.
// A registered ALU model sits on the alu_* side.
module tb_alu_arb;
    localparam int ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4;
    localparam int XOR = 5, SRL = 6, SRA = 7, OR = 8, AND = 9;
    localparam int BAD = 10;
`ifdef ALU_ARB_LEGAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          mn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
    } pay_t;

    typedef struct {
        bit          id;
        pay_t        p;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   nbad = 0;
    bit   exp_last = 1'b1;
    logic [31:0] exp_in1 = '0;
    logic [31:0] exp_in2 = '0;
    int   acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arb_if #(.XLEN(32), .TAG_W(5)) bus ();

    alu_arb #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] alu_f(input logic [6:0] f7,
        input logic [2:0] f3, input logic [4:0] opc,
        input logic [31:0] a, input logic [31:0] b);
        if (opc != 5'b01100) return 32'd0;
        case ({f7, f3})
            10'b0000000_000: return a + b;
            10'b0100000_000: return a - b;
            10'b0000000_001: return a << b[4:0];
            10'b0000000_010: return {31'd0, $signed(a) < $signed(b)};
            10'b0000000_011: return {31'd0, a < b};
            10'b0000000_100: return a ^ b;
            10'b0000000_101: return a >> b[4:0];
            10'b0100000_101: return $unsigned($signed(a) >>> b[4:0]);
            10'b0000000_110: return a | b;
            10'b0000000_111: return a & b;
            default:         return 32'd0;
        endcase
    endfunction

    always @(posedge clk)
        bus.alu_out <= alu_f(bus.alu_funct7, bus.alu_funct3,
                             bus.alu_opcode, bus.alu_in1, bus.alu_in2);

    function automatic logic [14:0] enc(input int mn);
        case (mn)
            ADD:  return {7'h00, 3'd0, 5'b01100};
            SUB:  return {7'h20, 3'd0, 5'b01100};
            SLL:  return {7'h00, 3'd1, 5'b01100};
            SLT:  return {7'h00, 3'd2, 5'b01100};
            SLTU: return {7'h00, 3'd3, 5'b01100};
            XOR:  return {7'h00, 3'd4, 5'b01100};
            SRL:  return {7'h00, 3'd5, 5'b01100};
            SRA:  return {7'h20, 3'd5, 5'b01100};
            OR:   return {7'h00, 3'd6, 5'b01100};
            AND:  return {7'h00, 3'd7, 5'b01100};
            default: return 15'h7FFF;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(input pay_t p);
        longint sa, sb;
        sa = longint'($signed(p.a));
        sb = longint'($signed(p.b));
        case (p.mn)
            ADD:  return p.a + p.b;
            SUB:  return p.a - p.b;
            SLL:  return p.a * (32'd1 << p.b[4:0]);
            SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            SLTU: return (p.a < p.b) ? 32'd1 : 32'd0;
            XOR:  return p.a ^ p.b;
            SRL:  return p.a / (32'd1 << p.b[4:0]);
            SRA:  return 32'(sa >>> p.b[4:0]);
            OR:   return p.a | p.b;
            AND:  return p.a & p.b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit v0, input bit v1,
                         input pay_t p0, input pay_t p1);
        bus.r0_valid = v0;
        bus.r0_op    = enc(p0.mn);
        bus.r0_a     = p0.a;
        bus.r0_b     = p0.b;
        bus.r0_tag   = p0.tag;
        bus.r1_valid = v1;
        bus.r1_op    = enc(p1.mn);
        bus.r1_a     = p1.a;
        bus.r1_b     = p1.b;
        bus.r1_tag   = p1.tag;
    endtask

    // Starts and ends just after a rising edge.
    task automatic run(input bit v0, input bit v1,
                       input pay_t p0, input pay_t p1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input int stall);
        bit w, got, r0s, r1s, ill;
        pay_t pw;
        logic [31:0] ew;
        int n, lat;
        w  = (v0 && v1) ? !exp_last : !v0;
        pw = w ? p1 : p0;
        ew = w ? e1 : e0;
        bus.rsp_ready = (stall == 0);
        drive(v0, v1, p0, p1);
        got = 1'b0;
        r0s = 1'b0;
        r1s = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            r0s = bus.r0_ready;
            r1s = bus.r1_ready;
            got = r0s || r1s;
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            chk("grant_timeout", 32'd0, 32'd1);
            drive(1'b0, 1'b0, p0, p1);
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            return;
        end
        chk("grant_r0", 32'(r0s), 32'(!w));
        chk("grant_r1", 32'(r1s), 32'(w));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        drive(1'b0, 1'b0, p0, p1);
        exp_last = w;
        ill = CHK && (pw.mn == BAD);
        lat = ill ? 2 : 3;
        if (!ill) begin
            exp_in1 = pw.a;
            exp_in2 = pw.b;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("busy_after_acc", 32'(bus.busy), 32'd1);
                chk("alu_in1", bus.alu_in1, exp_in1);
                chk("alu_in2", bus.alu_in2, exp_in2);
            end
            got = bus.rsp_valid;
        end
        chk("rsp_latency", 32'(n), 32'(lat));
        if (got) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(w));
            chk("rsp_tag", 32'(bus.rsp_tag), 32'(pw.tag));
            chk("rsp_data", bus.rsp_data, ew);
            chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(ill));
        end
        if (stall > 0) begin
            bus.r0_valid = 1'b1;
            bus.r1_valid = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
                chk("stall_data", bus.rsp_data, ew);
                chk("stall_ready",
                    32'({bus.r0_ready, bus.r1_ready}), 32'd0);
            end
            bus.r0_valid = 1'b0;
            bus.r1_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[11];
        pay_t z, pa, pb, pr;
        logic [31:0] first;
        int t0;
        z = '{ADD, 32'd0, 32'd0, 5'd0};
        tv[0]  = '{1'b0, '{ADD, 32'd5, 32'd7, 5'd3}, 32'd12};
        tv[1]  = '{1'b1, '{SUB, 32'd10, 32'd3, 5'd4}, 32'd7};
        tv[2]  = '{1'b0, '{SRA, 32'h80000000, 32'd4, 5'd5},
                   32'hF8000000};
        tv[3]  = '{1'b1, '{SLT, 32'hFFFFFFFF, 32'd1, 5'd6}, 32'd1};
        tv[4]  = '{1'b0, '{SLTU, 32'hFFFFFFFF, 32'd1, 5'd7}, 32'd0};
        tv[5]  = '{1'b1, '{XOR, 32'h0000F0F0, 32'h0000FF00, 5'd8},
                   32'h00000FF0};
        tv[6]  = '{1'b0, '{SLL, 32'd1, 32'd31, 5'd9}, 32'h80000000};
        tv[7]  = '{1'b1, '{SRL, 32'h80000000, 32'd31, 5'd10}, 32'd1};
        tv[8]  = '{1'b0, '{OR, 32'hA, 32'h5, 5'd11}, 32'hF};
        tv[9]  = '{1'b1, '{AND, 32'hC, 32'hA, 5'd12}, 32'h8};
        tv[10] = '{1'b0, '{ADD, 32'hFFFFFFFF, 32'd1, 5'd31}, 32'd0};

        bus.rsp_ready = 1'b1;
        drive(1'b1, 1'b1, tv[0].p, tv[1].p);
        @(negedge clk);
        chk("rst_ready", 32'({bus.r0_ready, bus.r1_ready}), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", bus.rsp_data, 32'd0);
        chk("rst_alu_in1", bus.alu_in1, 32'd0);
        chk("rst_alu_op", 32'({bus.alu_funct7, bus.alu_funct3,
                               bus.alu_opcode}), 32'd0);
        drive(1'b0, 1'b0, z, z);
        rst = 1'b1;
        @(posedge clk);
        #1;

        pa = '{SUB, 32'd10, 32'd3, 5'd1};
        pb = '{SRA, 32'h80000000, 32'd4, 5'd2};
        run(1'b1, 1'b1, pa, pb, 32'd7, 32'hF8000000, 0);
        run(1'b1, 1'b1, pa, pb, 32'd7, 32'hF8000000, 0);
        run(1'b1, 1'b1, pa, pb, 32'd7, 32'hF8000000, 0);

        for (int i = 0; i < 11; i++)
            run(!tv[i].id, tv[i].id, tv[i].p, tv[i].p,
                tv[i].exp, tv[i].exp, 0);

        run(1'b0, 1'b1, z, tv[5].p, 32'd0, tv[5].exp, 5);

        run(1'b1, 1'b0, tv[3].p, z, tv[3].exp, 32'd0, 0);
        t0 = acc_cyc;
        run(1'b1, 1'b0, tv[4].p, z, tv[4].exp, 32'd0, 0);
        chk("b2b_spacing", 32'(acc_cyc - t0), 32'd4);

        pb = '{BAD, 32'h12345678, 32'h9ABCDEF0, 5'd17};
        run(1'b0, 1'b1, z, pb, 32'd0, 32'd0, 0);

        pa = '{ADD, 32'd3, 32'd4, 5'd2};
        drive(1'b1, 1'b0, pa, z);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, z, z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_alu_in1", bus.alu_in1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_last = 1'b1;
        exp_in1 = '0;
        exp_in2 = '0;
        @(posedge clk);
        #1;
        pa = '{ADD, 32'd1, 32'd1, 5'd9};
        run(1'b1, 1'b0, pa, z, 32'd2, 32'd0, 0);

        for (int r = 0; r < 40; r++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            pa = '{int'($urandom_range(0, 10)), $urandom, $urandom,
                   5'($urandom)};
            pr = '{int'($urandom_range(0, 10)), $urandom, $urandom,
                   5'($urandom)};
            if (r % 4 == 0) begin
                first = 32'hFFFF_0000 | pa.a;
                pa.a = first;
            end
            run(v0, v1, pa, pr, ref_res(pa), ref_res(pr),
                int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
